// File: rtl/mem_access_ctrl_if.sv
// Request/response and memory-port bundle for the memory-access sequencer.
// The master side issues requests and returns memory read data; the slave side is the sequencer.
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Request side
  logic              req;
  logic              req_wr;
  logic              req_ifetch;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  // Status and results
  logic              busy;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] instr;
  logic [5:0]        Op;
  logic [5:0]        Funct;

  // Synchronous memory port
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output req, req_wr, req_ifetch, req_addr, req_wdata, mem_rdata,
    input  busy, done, err, rdata, instr, Op, Funct, mem_addr, mem_wdata, mem_wr
  );

  modport slave (
    input  req, req_wr, req_ifetch, req_addr, req_wdata, mem_rdata,
    output busy, done, err, rdata, instr, Op, Funct, mem_addr, mem_wdata, mem_wr
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory-access sequencer: runs one read or write against a fixed-latency synchronous memory
// and captures read data into the instruction word or the data word.
module mem_access_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 2   // legal range 1..15, fits the 4-bit countdown
) (
  input  logic             Clk,
  input  logic             Reset,
  mem_access_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  localparam logic [3:0] READ_CNT = 4'(MEM_LATENCY - 1);

  state_e            state_q,  state_d;
  logic [3:0]        cnt_q,    cnt_d;
  logic [ADDR_W-1:0] addr_q,   addr_d;
  logic [DATA_W-1:0] wdata_q,  wdata_d;
  logic              wr_q,     wr_d;
  logic              ifetch_q, ifetch_d;
  logic              err_q,    err_d;
  logic [DATA_W-1:0] rdata_q,  rdata_d;
  logic [DATA_W-1:0] instr_q,  instr_d;

  always_comb begin
    // NOTE: every _d takes its held value first, so no path through the case leaves one unassigned (no latches).
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wr_d     = wr_q;
    ifetch_d = ifetch_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    instr_d  = instr_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          addr_d   = bus.req_addr;
          wdata_d  = bus.req_wdata;
          wr_d     = bus.req_wr;
          ifetch_d = bus.req_ifetch;
          if (bus.req_addr[1:0] != 2'b00) begin
            // Misaligned: skip the memory entirely and report at completion.
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            err_d   = 1'b0;
            cnt_d   = bus.req_wr ? 4'd0 : READ_CNT;
            state_d = S_ACCESS;
          end
        end
      end

      S_ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = S_DONE;
          if (!wr_q) begin
            if (ifetch_q) instr_d = bus.mem_rdata;
            else          rdata_d = bus.mem_rdata;
          end
        end
      end

      S_DONE:  state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    // NOTE: state updates use non-blocking assignments so every flop sees pre-edge values.
    if (!Reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wr_q     <= 1'b0;
      ifetch_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      instr_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wr_q     <= wr_d;
      ifetch_q <= ifetch_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      instr_q  <= instr_d;
    end
  end

  // Strobes decode straight from state so a reset drops them without waiting for an edge.
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.err       = (state_q == S_DONE) && err_q;
  assign bus.mem_wr    = (state_q == S_ACCESS) && wr_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.rdata     = rdata_q;
  assign bus.instr     = instr_q;
  assign bus.Op        = instr_q[31:26];
  assign bus.Funct     = instr_q[5:0];

endmodule
